// File: rtl/top_level.sv
// Extended Hamming (15,11)+overall-parity encoder.
// Reads 15 eleven-bit messages from bytes 0..29 of an internal 256-byte
// memory and writes the encoded 16-bit words to bytes 30..59.
// Encoding starts as soon as reset is released; done rises once all
// 15 messages have been written and holds until the next reset.

// 256 x 8 data memory: combinational read, synchronous write-enable write.
// Contents are deliberately untouched by reset so preloaded data survives.
module data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] core [256];

   // Asynchronous read of the currently addressed byte
   assign rdata = core[addr];

   // One write per clock when enabled
   always_ff @(posedge clk) begin
      if (we) begin
         core[addr] <= wdata;
      end
   end

endmodule

module top_level (
   input  logic clk,
   input  logic reset,
   output logic done
);

   typedef enum logic [2:0] {
      LD_LO = 3'd0,
      LD_HI = 3'd1,
      ST_HI = 3'd2,
      ST_LO = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam logic [3:0] LAST_MSG = 4'd14;

   state_t     state_q, state_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [7:0] lo_q,    lo_d;     // d[8:1]
   logic [2:0] hi_q,    hi_d;     // d[11:9]
   logic       done_q,  done_d;

   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   logic [11:1] d;
   logic        p8, p4, p2, p1, p0;
   logic [7:0]  enc_hi, enc_lo;
   logic [7:0]  msg_base;

   data_mem dm1 (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign d        = {hi_q, lo_q};
   assign msg_base = {3'b000, cnt_q, 1'b0};

   // Parity bits and the two packed output bytes from the latched message
   always_comb begin
      p8 = ^d[11:5];
      p4 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
      enc_hi = {d[11:5], p8};
      enc_lo = {d[4], d[3], d[2], p4, d[1], p2, p1, p0};
   end

   // Memory port steering; writes are suppressed while reset is held so
   // an unknown power-up state can never corrupt the memory
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = msg_base;
      mem_wdata = enc_lo;
      case (state_q)
         LD_LO: mem_addr = msg_base;
         LD_HI: mem_addr = msg_base + 8'd1;
         ST_HI: begin
            mem_we    = !reset;
            mem_addr  = msg_base + 8'd31;
            mem_wdata = enc_hi;
         end
         ST_LO: begin
            mem_we    = !reset;
            mem_addr  = msg_base + 8'd30;
            mem_wdata = enc_lo;
         end
         default: mem_we = 1'b0;
      endcase
   end

   // Controller next-state: load low byte, load high bits, store hi, store lo
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      done_d  = done_q;
      case (state_q)
         LD_LO: begin
            lo_d    = mem_rdata;
            state_d = LD_HI;
         end
         LD_HI: begin
            hi_d    = mem_rdata[2:0];
            state_d = ST_HI;
         end
         ST_HI: state_d = ST_LO;
         ST_LO: begin
            if (cnt_q == LAST_MSG) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 4'd1;
               state_d = LD_LO;
            end
         end
         FIN: done_d = 1'b1;
         default: state_d = LD_LO;
      endcase
   end

   // Controller registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LD_LO;
         cnt_q   <= 4'd0;
         lo_q    <= 8'd0;
         hi_q    <= 3'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         done_q  <= done_d;
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_top_level.sv
// Directed bench for the Hamming encoder: preloads the internal memory,
// runs the encoder and checks done timing and every output byte.
module tb_top_level;

   logic clk;
   logic reset;
   logic done;

   int n_cmp;
   int n_bad;

   // Per-message input bytes and hand-computed encoded bytes
   logic [7:0] in_lo  [15];
   logic [7:0] in_hi  [15];
   logic [7:0] exp_hi [15];
   logic [7:0] exp_lo [15];

   top_level dut (
      .clk   (clk),
      .reset (reset),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] tail_pat(input int a);
      tail_pat = 8'(a) ^ 8'h5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_outputs(input logic [7:0] v);
      for (int a = 30; a < 60; a++) dut.dm1.core[a] = v;
   endtask

   task automatic preload_vectors();
      for (int i = 0; i < 15; i++) begin
         dut.dm1.core[2*i]   = in_lo[i];
         dut.dm1.core[2*i+1] = in_hi[i];
      end
      fill_outputs(8'hEE);
      for (int a = 60; a < 256; a++) dut.dm1.core[a] = tail_pat(a);
   endtask

   // Release reset and check done is low on edges 1..59, high on 60..70
   task automatic run_and_check_done(input string tag);
      reset = 1'b0;
      for (int n = 1; n <= 70; n++) begin
         tick();
         n_cmp++;
         if (done !== (n >= 60)) begin
            n_bad++;
            $display("FAIL %s done at edge %0d: got %b want %b", tag, n, done, (n >= 60));
         end
         if (n == 59) begin
            n_cmp++;
            if (dut.dm1.core[58] !== 8'hEE) begin
               n_bad++;
               $display("FAIL %s early lo write of msg14: got %h want ee", tag, dut.dm1.core[58]);
            end
         end
      end
   endtask

   task automatic check_encoded(input string tag);
      for (int i = 0; i < 15; i++) begin
         n_cmp += 2;
         if (dut.dm1.core[31+2*i] !== exp_hi[i]) begin
            n_bad++;
            $display("FAIL %s hi msg%0d: got %h want %h", tag, i, dut.dm1.core[31+2*i], exp_hi[i]);
         end
         if (dut.dm1.core[30+2*i] !== exp_lo[i]) begin
            n_bad++;
            $display("FAIL %s lo msg%0d: got %h want %h", tag, i, dut.dm1.core[30+2*i], exp_lo[i]);
         end
         $display("%s msg%0d in=%h_%h out=%h_%h", tag, i, in_hi[i], in_lo[i],
                  dut.dm1.core[31+2*i], dut.dm1.core[30+2*i]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      preload_vectors();
      repeat (5) tick();
      n_cmp += 2;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset done: got %b want 0", done);
      end
      if (dut.dm1.core[31] !== 8'hEE) begin
         n_bad++;
         $display("FAIL reset no-write: got %h want ee", dut.dm1.core[31]);
      end
      $display("reset: done=%b core31=%h", done, dut.dm1.core[31]);
   endtask

   task automatic test_all_zero();
      int first;
      reset = 1'b1;
      for (int a = 0; a < 30; a++) dut.dm1.core[a] = 8'h00;
      fill_outputs(8'hEE);
      repeat (5) tick();
      reset = 1'b0;
      first = 0;
      for (int n = 1; n <= 64 && first == 0; n++) begin
         tick();
         if (done === 1'b1) first = n;
      end
      n_cmp++;
      if (first != 60) begin
         n_bad++;
         $display("FAIL zero done edge: got %0d want 60", first);
      end
      for (int a = 30; a < 60; a++) begin
         n_cmp++;
         if (dut.dm1.core[a] !== 8'h00) begin
            n_bad++;
            $display("FAIL zero out[%0d]: got %h want 00", a, dut.dm1.core[a]);
         end
      end
      $display("all_zero: done edge=%0d", first);
   endtask

   task automatic test_vectors();
      reset = 1'b1;
      preload_vectors();
      repeat (3) tick();
      run_and_check_done("vec");
      check_encoded("vec");
      for (int i = 0; i < 15; i++) begin
         n_cmp += 2;
         if (dut.dm1.core[2*i] !== in_lo[i] || dut.dm1.core[2*i+1] !== in_hi[i]) begin
            n_bad++;
            $display("FAIL vec input msg%0d: got %h_%h want %h_%h", i,
                     dut.dm1.core[2*i+1], dut.dm1.core[2*i], in_hi[i], in_lo[i]);
         end
      end
      for (int a = 60; a < 256; a++) begin
         n_cmp++;
         if (dut.dm1.core[a] !== tail_pat(a)) begin
            n_bad++;
            $display("FAIL vec tail[%0d]: got %h want %h", a, dut.dm1.core[a], tail_pat(a));
         end
      end
   endtask

   task automatic test_back_to_back();
      // done must drop on the first reset edge after a completed run
      reset = 1'b1;
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort done drop after finish: got %b want 0", done);
      end
      fill_outputs(8'hEE);
      repeat (2) tick();
      reset = 1'b0;
      repeat (20) tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort done mid-run: got %b want 0", done);
      end
      // Messages 0..4 were written in 20 edges; the rest must be untouched
      for (int i = 0; i < 5; i++) begin
         n_cmp += 2;
         if (dut.dm1.core[31+2*i] !== exp_hi[i] || dut.dm1.core[30+2*i] !== exp_lo[i]) begin
            n_bad++;
            $display("FAIL abort kept msg%0d: got %h_%h want %h_%h", i,
                     dut.dm1.core[31+2*i], dut.dm1.core[30+2*i], exp_hi[i], exp_lo[i]);
         end
      end
      for (int a = 40; a < 60; a++) begin
         n_cmp++;
         if (dut.dm1.core[a] !== 8'hEE) begin
            n_bad++;
            $display("FAIL abort unwritten[%0d]: got %h want ee", a, dut.dm1.core[a]);
         end
      end
      $display("abort: done=%b core30=%h core40=%h", done, dut.dm1.core[30], dut.dm1.core[40]);
      repeat (4) tick();
      run_and_check_done("restart");
      check_encoded("restart");
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      // msg: input (hi,lo) -> expected (hi,lo)
      in_lo  = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h10, 8'h80,
                 8'h00, 8'h55, 8'hAA, 8'hFF, 8'hF0, 8'h0F, 8'h23};
      in_hi  = '{8'h07, 8'h00, 8'h04, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h05, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h01};
      exp_hi = '{8'hFF, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h03, 8'h11,
                 8'h21, 8'hAA, 8'h55, 8'hFF, 8'h1E, 8'h00, 8'h24};
      exp_lo = '{8'hFF, 8'h0F, 8'h17, 8'h00, 8'h00, 8'h33, 8'h03, 8'h11,
                 8'h12, 8'h5A, 8'hA5, 8'hFF, 8'h11, 8'hFF, 8'h2B};
      test_reset();
      test_all_zero();
      test_vectors();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
